// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

    localparam int DIGIT_W      = 4;
    localparam int BLINK_FRAMES = 32;

    // Counter wide enough to hold the longer of the two intervals.
    function automatic int cnt_width(input int dwell, input int dead);
        int m;
        m = (dwell > dead) ? dwell : dead;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; tc is high during the last cycle of a loaded interval.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               count <= '0;
        else if (clear)          count <= '0;
        else if (load)           count <= load_val;
        else if (count != '0)    count <= count - 1'b1;
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed signed-digit scan with dead-time blanking and frame-aligned
// double buffering. Optional blink support under DISPLAY_SCAN_BLINK_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DWELL    = 50000,
    parameter int DEAD     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        load,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic [N_DIGITS-1:0]         blink_mask,
`endif
    input  logic [DIGIT_W*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]         sign_in,
    output logic [DIGIT_W-1:0]          diff,
    output logic                        sinal,
    output logic [N_DIGITS-1:0]         digit_sel,
    output logic                        frame_start,
    output logic                        pending
);

    localparam int CW = cnt_width(DWELL, DEAD);
    localparam int IW = ($clog2(N_DIGITS) < 1) ? 1 : $clog2(N_DIGITS);

    scan_state_e state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;

    logic [CW-1:0] tmr_count, tmr_val;
    logic          tmr_tc, tmr_load, tmr_clear;

    logic enter_blank, boundary, wrap, commit;

    logic [N_DIGITS-1:0][DIGIT_W-1:0] value_arr, shadow_val, active_val, active_nxt;
    logic [N_DIGITS-1:0]              shadow_sgn, active_sgn, active_sgn_nxt;
    logic [N_DIGITS-1:0]              sel_nxt, blank_mask;

    assign value_arr = value_in;

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A zero count in BLANK means the scan is idle (after reset or enable low);
    // while scanning the timer is always reloaded before it reaches zero.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        tmr_clear   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        enter_blank = 1'b0;
        boundary    = 1'b0;
        wrap        = 1'b0;
        if (!enable) begin
            state_nxt = BLANK;
            idx_nxt   = '0;
            tmr_clear = 1'b1;
        end else begin
            unique case (state)
                BLANK: begin
                    if (tmr_count == '0) begin
                        enter_blank = 1'b1;
                        boundary    = 1'b1;
                        idx_nxt     = '0;
                        tmr_load    = 1'b1;
                        tmr_val     = CW'(DEAD);
                    end else if (tmr_tc) begin
                        state_nxt = SHOW;
                        tmr_load  = 1'b1;
                        tmr_val   = CW'(DWELL);
                    end
                end
                SHOW: begin
                    if (tmr_tc) begin
                        state_nxt   = BLANK;
                        enter_blank = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_val     = CW'(DEAD);
                        if (idx == IW'(N_DIGITS - 1)) begin
                            idx_nxt  = '0;
                            boundary = 1'b1;
                            wrap     = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end
    end

    always_comb begin
        commit         = boundary && pending;
        active_nxt     = commit ? shadow_val : active_val;
        active_sgn_nxt = commit ? shadow_sgn : active_sgn;
        for (int i = 0; i < N_DIGITS; i++)
            sel_nxt[i] = !((state_nxt == SHOW) && (idx_nxt == IW'(i)) && !blank_mask[i]);
    end

    // Decoder inputs change only on BLANK entry, giving them DEAD cycles to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            diff        <= '0;
            sinal       <= 1'b0;
            digit_sel   <= '1;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            shadow_val  <= '0;
            shadow_sgn  <= '0;
            active_val  <= '0;
            active_sgn  <= '0;
        end else begin
            frame_start <= boundary;
            digit_sel   <= sel_nxt;
            active_val  <= active_nxt;
            active_sgn  <= active_sgn_nxt;
            if (enter_blank) begin
                diff  <= active_nxt[idx_nxt];
                sinal <= active_sgn_nxt[idx_nxt];
            end
            if (load) begin
                shadow_val <= value_arr;
                shadow_sgn <= sign_in;
                pending    <= 1'b1;
            end else if (commit) begin
                pending    <= 1'b0;
            end
        end
    end

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES);

    logic [FW-1:0] frame_cnt;
    logic          blink_off;

    // Counting completed frames makes the toggle land on the boundary of frame 32, 64, ...
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (frame_cnt == FW'(BLINK_FRAMES - 1))
                blink_off <= ~blink_off;
        end
    end

    assign blank_mask = blink_off ? blink_mask : '0;
`else
    assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a frame-position model.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int DD = 2;
    localparam int SL = DW + DD;
    localparam int F  = N * SL;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  sign_in = '0;
`ifdef DISPLAY_SCAN_BLINK_EN
    logic [3:0]  blink_mask = '0;
`endif
    logic [3:0]  diff, digit_sel;
    logic        sinal, frame_start, pending;

    int checks = 0, failures = 0;
    bit chk_on = 0;

    display_scan_ctrl #(.N_DIGITS(N), .DWELL(DW), .DEAD(DD)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
`ifdef DISPLAY_SCAN_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .value_in    (value_in),
        .sign_in     (sign_in),
        .diff        (diff),
        .sinal       (sinal),
        .digit_sel   (digit_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        int          k;
        logic [15:0] shadow, active;
        logic [3:0]  sshadow, sactive;
        bit          pend;
        logic [3:0]  diff, sel;
        logic        sinal, fs;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.run = 0; r.k = 0; r.shadow = '0; r.active = '0; r.sshadow = '0; r.sactive = '0;
        r.pend = 0; r.diff = '0; r.sel = 4'hF; r.sinal = 1'b0; r.fs = 1'b0;
        return r;
    endfunction

    // Outputs follow from the cycle's position inside the running frame.
    function automatic mdl_t mdl_next(input mdl_t c, input logic en, input logic ld,
                                      input logic [15:0] v, input logic [3:0] s);
        mdl_t n;
        int p, d, r;
        logic [3:0] one;
        n = c;
        one = 4'b0001;
        n.fs = 1'b0;
        if (!en) begin
            n.run = 0;
            n.sel = 4'hF;
        end else begin
            if (!c.run) begin n.run = 1; n.k = 0; end
            else n.k = c.k + 1;
            p = n.k % F;
            d = p / SL;
            r = p % SL;
            n.fs = (p == 0);
            if (p == 0 && c.pend) begin
                n.active = c.shadow; n.sactive = c.sshadow; n.pend = 0;
            end
            if (r == 0) begin
                n.diff  = n.active[4*d +: 4];
                n.sinal = n.sactive[d];
            end
            n.sel = (r >= DD) ? ~(one << d) : 4'hF;
        end
        if (ld) begin n.shadow = v; n.sshadow = s; n.pend = 1; end
        return n;
    endfunction

    mdl_t m;

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_reset();
        else       m <= mdl_next(m, enable, load, value_in, sign_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_diff", 32'(diff), 32'(m.diff));
            chk("m_sinal", 32'(sinal), 32'(m.sinal));
            chk("m_sel", 32'(digit_sel), 32'(m.sel));
            chk("m_fs", 32'(frame_start), 32'(m.fs));
            chk("m_pend", 32'(pending), 32'(m.pend));
        end
    end

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 3 * F);
        chk("wait_fs", 32'(frame_start), 32'd1);
    endtask

    logic [3:0] sel_tab [F] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                                4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
                                4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};

    initial begin
        int off;
        off = 0;
        #1 reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_sel", 32'(digit_sel), 32'hF);
        chk("rst_diff", 32'(diff), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        reset = 1'b0;

        // First frame after enable: literal scan pattern.
        for (int c = 0; c < F; c++) begin
            @(negedge clk);
            chk("seq_sel", 32'(digit_sel), 32'(sel_tab[c]));
            chk("seq_fs", 32'(frame_start), 32'(c == 0));
        end
        @(negedge clk);
        chk("seq_fs24", 32'(frame_start), 32'd1);

        // Mid-frame load; digit i = value_in[4i+3:4i].
        repeat (5) @(negedge clk);
        load = 1'b1; value_in = 16'h9351; sign_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        chk("ld_pend", 32'(pending), 32'd1);
        wait_fs();
        chk("ld_commit_pend", 32'(pending), 32'd0);
        chk("ld_d0", 32'({sinal, diff}), 32'h01);
        repeat (8) @(negedge clk);
        chk("ld_sel1", 32'(digit_sel), 32'hD);
        chk("ld_d1", 32'({sinal, diff}), 32'h05);
        repeat (6) @(negedge clk);
        chk("ld_sel2", 32'(digit_sel), 32'hB);
        chk("ld_d2", 32'({sinal, diff}), 32'h13);
        repeat (6) @(negedge clk);
        chk("ld_d3", 32'({sinal, diff}), 32'h09);

        // Two loads before the boundary: last wins.
        @(negedge clk);
        load = 1'b1; value_in = 16'h1111; sign_in = 4'b0000;
        @(negedge clk);
        value_in = 16'h2222; sign_in = 4'b1111;
        @(negedge clk);
        load = 1'b0;
        chk("dbl_pend", 32'(pending), 32'd1);
        @(negedge clk);
        chk("dbl_fs", 32'(frame_start), 32'd1);
        chk("dbl_d0", 32'({sinal, diff}), 32'h12);
        repeat (6) @(negedge clk);
        chk("dbl_d1", 32'({sinal, diff}), 32'h12);

        // Load A mid-frame, then load B sampled on the commit edge.
        load = 1'b1; value_in = 16'h0007; sign_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        repeat (16) @(negedge clk);
        load = 1'b1; value_in = 16'h000C; sign_in = 4'b0001;
        @(negedge clk);
        load = 1'b0;
        chk("co_fs", 32'(frame_start), 32'd1);
        chk("co_d0", 32'({sinal, diff}), 32'h07);
        chk("co_pend", 32'(pending), 32'd1);
        wait_fs();
        chk("co_d0_next", 32'({sinal, diff}), 32'h1C);
        chk("co_pend_next", 32'(pending), 32'd0);

        // Drop enable during digit 2 SHOW, then restart.
        repeat (15) @(negedge clk);
        chk("en_sel2", 32'(digit_sel), 32'hB);
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_sel", 32'(digit_sel), 32'hF);
        chk("en_off_fs", 32'(frame_start), 32'd0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("re_fs", 32'(frame_start), 32'd1);
        chk("re_sel0", 32'(digit_sel), 32'hF);
        @(negedge clk);
        chk("re_sel1", 32'(digit_sel), 32'hF);
        @(negedge clk);
        chk("re_sel2", 32'(digit_sel), 32'hE);

        // Random loads and enable drops.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            load     = ($urandom_range(0, 7) == 0);
            value_in = 16'($urandom);
            sign_in  = 4'($urandom_range(0, 15));
            if (enable && $urandom_range(0, 99) == 0) begin
                enable = 1'b0;
                off = $urandom_range(1, 6);
            end else if (!enable) begin
                off--;
                if (off <= 0) enable = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        enable = 1'b1;
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-scan.
        #2 reset = 1'b1;
        #1;
        chk("arst_sel", 32'(digit_sel), 32'hF);
        chk("arst_pend", 32'(pending), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * F) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
